// File: rtl/port_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : port_seq_ctrl                                                    |
// | Purpose : Sequencer in front of the 8-bit bidirectional port register pair.|
// |           CPU write bytes are queued in a small FIFO and presented on      |
// |           port_d/port_dir with a stb/ack handshake to the external device. |
// |           CPU reads turn the port to input, wait for the registered input  |
// |           path to settle and return the sampled port_in byte.             |
// | Ports   : clk, clear (async, active-low)                                   |
// |           wr_valid/wr_data/wr_ready  - CPU write byte stream               |
// |           rd_req/rd_data/rd_valid    - CPU read request and result         |
// |           busy                       - sequencer activity indicator        |
// |           port_d/port_dir/port_in    - port register d, in_out_en, Q_out   |
// |           stb/ack                    - external device handshake           |
// |           err_clr/timeout_err        - sticky ack-timeout flag             |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module port_seq_ctrl #(
  parameter int DEPTH       = 4,
  parameter int STB_CYCLES  = 2,
  parameter int ACK_TIMEOUT = 15,
  parameter int TURN_CYCLES = 2
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       wr_valid,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  input  logic       rd_req,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  output logic [7:0] port_d,
  output logic       port_dir,
  input  logic [7:0] port_in,
  output logic       stb,
  input  logic       ack,
  input  logic       err_clr,
  output logic       timeout_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] c_full      = CW'(DEPTH);
  localparam logic [7:0]    c_stb_last  = 8'(STB_CYCLES - 1);
  localparam logic [7:0]    c_ack_last  = 8'(ACK_TIMEOUT - 1);
  localparam logic [7:0]    c_turn_last = 8'(TURN_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_STROBE   = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_RELEASE  = 3'd4,
    ST_TURN     = 3'd5,
    ST_SAMPLE   = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          rd_pend_q, rd_pend_d;
  logic          ack_s1_q, ack_s2_q;
  logic [7:0]    port_d_q, port_d_d;
  logic          port_dir_q, port_dir_d;
  logic          stb_q, stb_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          timeout_err_q, timeout_err_d;
  logic          w_push, w_pop;

  // Full is judged from the registered count alone; a same-cycle pop does
  // not open a slot.
  assign wr_ready = (count_q != c_full);
  assign w_push   = wr_valid & wr_ready;
  assign busy     = (state_q != ST_IDLE) | (count_q != '0) | rd_pend_q;

  assign port_d      = port_d_q;
  assign port_dir    = port_dir_q;
  assign stb         = stb_q;
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign timeout_err = timeout_err_q;

  // FIFO storage carries no reset; an entry is only read after being written.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (w_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    port_d_d      = port_d_q;
    port_dir_d    = port_dir_q;
    rd_data_d     = rd_data_q;
    // A request while one is already pending simply merges into it.
    rd_pend_d     = rd_pend_q | rd_req;
    // Setting the flag below overrides this clear.
    timeout_err_d = timeout_err_q & ~err_clr;
    w_pop         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Queued writes always drain before a pending read is serviced.
        if (count_q != '0) begin
          state_d = ST_LOAD;
        end else if (rd_pend_q) begin
          state_d    = ST_TURN;
          port_dir_d = 1'b0;
          cnt_d      = '0;
        end
      end
      ST_LOAD: begin
        port_d_d   = mem_q[rd_ptr_q];
        port_dir_d = 1'b1;
        w_pop      = 1'b1;
        cnt_d      = '0;
        state_d    = ST_STROBE;
      end
      ST_STROBE: begin
        if (cnt_q == c_stb_last) begin
          cnt_d   = '0;
          state_d = ST_WAIT_ACK;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_WAIT_ACK: begin
        if (ack_s2_q) begin
          state_d = ST_RELEASE;
        end else if (cnt_q == c_ack_last) begin
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RELEASE: begin
        if (!ack_s2_q) state_d = ST_IDLE;
      end
      ST_TURN: begin
        // Direction has been input for the whole turn window, so the port's
        // input register now reflects the pins.
        if (cnt_q == c_turn_last) begin
          rd_data_d = port_in;
          state_d   = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_SAMPLE: begin
        rd_pend_d = 1'b0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    stb_d      = (state_d == ST_STROBE);
    rd_valid_d = (state_d == ST_SAMPLE);
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      rd_pend_q     <= 1'b0;
      ack_s1_q      <= 1'b0;
      ack_s2_q      <= 1'b0;
      port_d_q      <= 8'h00;
      port_dir_q    <= 1'b0;
      stb_q         <= 1'b0;
      rd_data_q     <= 8'h00;
      rd_valid_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      rd_pend_q     <= rd_pend_d;
      ack_s1_q      <= ack;
      ack_s2_q      <= ack_s1_q;
      port_d_q      <= port_d_d;
      port_dir_q    <= port_dir_d;
      stb_q         <= stb_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
      timeout_err_q <= timeout_err_d;
    end
  end

endmodule
`default_nettype wire
